// File: rtl/gpc1415_pkg.sv
// gpc1415_pkg -- shared column geometry, FSM states and reference sum for gpc1415_5 checkers.
// Revision 1.0
`default_nettype none

package gpc1415_pkg;

  localparam int SRC0_W  = 5;
  localparam int SRC1_W  = 1;
  localparam int SRC2_W  = 4;
  localparam int SRC3_W  = 1;
  localparam int W0      = 1;
  localparam int W1      = 2;
  localparam int W2      = 4;
  localparam int W3      = 8;
  localparam int MAX_SUM = 31;
  localparam int SUM_W   = 5;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  function automatic logic [SUM_W-1:0] weighted_sum(
    input logic [SRC0_W-1:0] s0,
    input logic [SRC1_W-1:0] s1,
    input logic [SRC2_W-1:0] s2,
    input logic [SRC3_W-1:0] s3
  );
    logic [SUM_W-1:0] p0;
    logic [SUM_W-1:0] p2;
    p0 = '0;
    p2 = '0;
    for (int i = 0; i < SRC0_W; i++) p0 = p0 + SUM_W'(s0[i]);
    for (int i = 0; i < SRC2_W; i++) p2 = p2 + SUM_W'(s2[i]);
    return p0 * SUM_W'(W0) + SUM_W'(s1) * SUM_W'(W1) + p2 * SUM_W'(W2) + SUM_W'(s3) * SUM_W'(W3);
  endfunction

endpackage

`default_nettype wire

// File: rtl/gpc1415_refsum.sv
// gpc1415_refsum -- combinational reference column sum for one gpc1415_5 input vector.
// Revision 1.0
`default_nettype none

module gpc1415_refsum
  import gpc1415_pkg::*;
(
  input  logic [SRC0_W-1:0] src0_i,
  input  logic [SRC1_W-1:0] src1_i,
  input  logic [SRC2_W-1:0] src2_i,
  input  logic [SRC3_W-1:0] src3_i,
  output logic [SUM_W-1:0]  ref_sum_o
);

  assign ref_sum_o = weighted_sum(src0_i, src1_i, src2_i, src3_i);

endmodule

`default_nettype wire

// File: rtl/gpc1415_frame_checker.sv
// gpc1415_frame_checker -- checks gpc1415_5 results against a recomputed sum and emits per-frame summaries.
// Revision 1.0
`default_nettype none

module gpc1415_frame_checker
  import gpc1415_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1),
  parameter int ACC_W     = $clog2(MAX_SUM * FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       src0,
  input  logic             src1,
  input  logic [3:0]       src2,
  input  logic             src3,
  input  logic [4:0]       dst,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic [ACC_W-1:0] frame_sum,
  output logic [CNT_W-1:0] frame_err_cnt,
  output logic             frame_err,
  output logic [CNT_W-1:0] frame_first_err_idx
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_e state_q, state_d;

  logic [CNT_W-1:0] idx_q, idx_d;
  logic             s1_valid_q, s1_valid_d;
  logic [4:0]       s1_src0_q, s1_src0_d;
  logic             s1_src1_q, s1_src1_d;
  logic [3:0]       s1_src2_q, s1_src2_d;
  logic             s1_src3_q, s1_src3_d;
  logic [4:0]       s1_dst_q, s1_dst_d;
  logic             s1_last_q, s1_last_d;
  logic [CNT_W-1:0] s1_idx_q, s1_idx_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] first_idx_q, first_idx_d;
  logic             frame_valid_q, frame_valid_d;
  logic [ACC_W-1:0] frame_sum_q, frame_sum_d;
  logic [CNT_W-1:0] frame_err_cnt_q, frame_err_cnt_d;
  logic             frame_err_q, frame_err_d;
  logic [CNT_W-1:0] frame_first_q, frame_first_d;

  logic [SUM_W-1:0] ref_sum;
  logic             accept;
  logic             last;
  logic             clear_eff;
  logic             mismatch;
  logic [ACC_W-1:0] acc_upd;
  logic [CNT_W-1:0] err_upd;
  logic [CNT_W-1:0] first_upd;

  gpc1415_refsum u_refsum (
    .src0_i    (s1_src0_q),
    .src1_i    (s1_src1_q),
    .src2_i    (s1_src2_q),
    .src3_i    (s1_src3_q),
    .ref_sum_o (ref_sum)
  );

  // A summary waiting in HOLD must survive clear.
  assign clear_eff = clear && (state_q != ST_HOLD);
  assign accept    = in_valid && in_ready;
  assign last      = (idx_q == LAST_IDX);
  assign mismatch  = (s1_dst_q != ref_sum);
  assign acc_upd   = acc_q + ACC_W'(s1_dst_q);
  assign err_upd   = err_cnt_q + CNT_W'(mismatch);
  assign first_upd = (mismatch && (err_cnt_q == '0)) ? s1_idx_q : first_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_ACCUM;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM: if (!clear && accept && last) state_d = ST_DRAIN;
      ST_DRAIN: state_d = clear ? ST_ACCUM : ST_HOLD;
      ST_HOLD:  if (frame_valid_q && frame_ready) state_d = ST_ACCUM;
      default:  state_d = ST_ACCUM;
    endcase
  end

  always_comb begin
    in_ready = (state_q == ST_ACCUM) && !clear;
  end

  always_comb begin
    idx_d           = idx_q;
    s1_valid_d      = accept && !clear_eff;
    s1_src0_d       = s1_src0_q;
    s1_src1_d       = s1_src1_q;
    s1_src2_d       = s1_src2_q;
    s1_src3_d       = s1_src3_q;
    s1_dst_d        = s1_dst_q;
    s1_last_d       = s1_last_q;
    s1_idx_d        = s1_idx_q;
    acc_d           = acc_q;
    err_cnt_d       = err_cnt_q;
    first_idx_d     = first_idx_q;
    frame_valid_d   = frame_valid_q;
    frame_sum_d     = frame_sum_q;
    frame_err_cnt_d = frame_err_cnt_q;
    frame_err_d     = frame_err_q;
    frame_first_d   = frame_first_q;

    if (clear_eff) begin
      idx_d = '0;
    end else if (accept) begin
      idx_d     = last ? '0 : idx_q + CNT_W'(1);
      s1_src0_d = src0;
      s1_src1_d = src1;
      s1_src2_d = src2;
      s1_src3_d = src3;
      s1_dst_d  = dst;
      s1_last_d = last;
      s1_idx_d  = idx_q;
    end

    if (clear_eff) begin
      acc_d       = '0;
      err_cnt_d   = '0;
      first_idx_d = '0;
    end else if (s1_valid_q) begin
      if (s1_last_q) begin
        frame_valid_d   = 1'b1;
        frame_sum_d     = acc_upd;
        frame_err_cnt_d = err_upd;
        frame_err_d     = (err_upd != '0);
        frame_first_d   = first_upd;
        acc_d           = '0;
        err_cnt_d       = '0;
        first_idx_d     = '0;
      end else begin
        acc_d       = acc_upd;
        err_cnt_d   = err_upd;
        first_idx_d = first_upd;
      end
    end

    if ((state_q == ST_HOLD) && frame_valid_q && frame_ready) frame_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q           <= '0;
      s1_valid_q      <= 1'b0;
      s1_src0_q       <= '0;
      s1_src1_q       <= 1'b0;
      s1_src2_q       <= '0;
      s1_src3_q       <= 1'b0;
      s1_dst_q        <= '0;
      s1_last_q       <= 1'b0;
      s1_idx_q        <= '0;
      acc_q           <= '0;
      err_cnt_q       <= '0;
      first_idx_q     <= '0;
      frame_valid_q   <= 1'b0;
      frame_sum_q     <= '0;
      frame_err_cnt_q <= '0;
      frame_err_q     <= 1'b0;
      frame_first_q   <= '0;
    end else begin
      idx_q           <= idx_d;
      s1_valid_q      <= s1_valid_d;
      s1_src0_q       <= s1_src0_d;
      s1_src1_q       <= s1_src1_d;
      s1_src2_q       <= s1_src2_d;
      s1_src3_q       <= s1_src3_d;
      s1_dst_q        <= s1_dst_d;
      s1_last_q       <= s1_last_d;
      s1_idx_q        <= s1_idx_d;
      acc_q           <= acc_d;
      err_cnt_q       <= err_cnt_d;
      first_idx_q     <= first_idx_d;
      frame_valid_q   <= frame_valid_d;
      frame_sum_q     <= frame_sum_d;
      frame_err_cnt_q <= frame_err_cnt_d;
      frame_err_q     <= frame_err_d;
      frame_first_q   <= frame_first_d;
    end
  end

  assign frame_valid         = frame_valid_q;
  assign frame_sum           = frame_sum_q;
  assign frame_err_cnt       = frame_err_cnt_q;
  assign frame_err           = frame_err_q;
  assign frame_first_err_idx = frame_first_q;

endmodule

`default_nettype wire

// File: tb/tb_gpc1415_frame_checker.sv
// tb_gpc1415_frame_checker -- directed self-checking bench for gpc1415_frame_checker (FRAME_LEN=4).
// Revision 1.0
`default_nettype none

module tb_gpc1415_frame_checker;

  localparam int FRAME_LEN = 4;
  localparam int CNT_W     = 3;
  localparam int ACC_W     = 7;

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       src0;
  logic             src1;
  logic [3:0]       src2;
  logic             src3;
  logic [4:0]       dst;
  logic             frame_valid;
  logic             frame_ready;
  logic [ACC_W-1:0] frame_sum;
  logic [CNT_W-1:0] frame_err_cnt;
  logic             frame_err;
  logic [CNT_W-1:0] frame_first_err_idx;

  int n_checks = 0;
  int n_errors = 0;

  logic [4:0] s0_tab [4] = '{5'h08, 5'h14, 5'h0C, 5'h19};
  logic       s1_tab [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [3:0] s2_tab [4] = '{4'hE, 4'h4, 4'h5, 4'h2};
  logic       s3_tab [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  logic [4:0] dcur   [4];

  gpc1415_frame_checker #(.FRAME_LEN(FRAME_LEN)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .clear               (clear),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .src0                (src0),
    .src1                (src1),
    .src2                (src2),
    .src3                (src3),
    .dst                 (dst),
    .frame_valid         (frame_valid),
    .frame_ready         (frame_ready),
    .frame_sum           (frame_sum),
    .frame_err_cnt       (frame_err_cnt),
    .frame_err           (frame_err),
    .frame_first_err_idx (frame_first_err_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic send(input logic [4:0] a, input logic b, input logic [3:0] c, input logic e,
                      input logic [4:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    src0 = a; src1 = b; src2 = c; src3 = e; dst = d;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int gap);
    for (int k = 0; k < 4; k++) begin
      send(s0_tab[k], s1_tab[k], s2_tab[k], s3_tab[k], dcur[k]);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    while (!frame_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_frame(input string tag, input int sum, input int cnt, input int err, input int idx);
    chk({tag, "_sum"}, 32'(frame_sum), 32'(sum));
    chk({tag, "_errcnt"}, 32'(frame_err_cnt), 32'(cnt));
    chk({tag, "_err"}, 32'(frame_err), 32'(err));
    chk({tag, "_firstidx"}, 32'(frame_first_err_idx), 32'(idx));
  endtask

  task automatic handshake(input string tag);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    chk({tag, "_hs_fvalid"}, 32'(frame_valid), 32'd0);
    chk({tag, "_hs_inready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_inready"}, 32'(in_ready), 32'd1);
    chk({tag, "_fvalid"}, 32'(frame_valid), 32'd0);
    check_frame(tag, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; clear = 1'b0; in_valid = 1'b0; frame_ready = 1'b0;
    src0 = '0; src1 = 1'b0; src2 = '0; src3 = 1'b0; dst = '0;
    #1 rst_n = 1'b0;
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // clean frame, with drain-cycle latency check
    dcur = '{5'h0F, 5'h0E, 5'h14, 5'h0F};
    send_frame(0);
    chk("drain_inready", 32'(in_ready), 32'd0);
    chk("drain_fvalid", 32'(frame_valid), 32'd0);
    @(negedge clk);
    chk("latency_fvalid", 32'(frame_valid), 32'd1);
    check_frame("clean", 64, 0, 0, 0);
    handshake("clean");

    // one error at index 2, consumer stalls 5 cycles
    dcur = '{5'h0F, 5'h0E, 5'h10, 5'h0F};
    send_frame(0);
    wait_frame();
    check_frame("err2", 60, 1, 1, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_fvalid", 32'(frame_valid), 32'd1);
      chk("stall_inready", 32'(in_ready), 32'd0);
      chk("stall_sum", 32'(frame_sum), 32'd60);
      chk("stall_idx", 32'(frame_first_err_idx), 32'd2);
    end
    handshake("stall");

    // clear after two samples (first one erroneous) discards them
    dcur = '{5'h00, 5'h0E, 5'h14, 5'h0F};
    send(s0_tab[0], s1_tab[0], s2_tab[0], s3_tab[0], dcur[0]);
    send(s0_tab[1], s1_tab[1], s2_tab[1], s3_tab[1], dcur[1]);
    clear = 1'b1;
    in_valid = 1'b1;
    src0 = s0_tab[2]; src1 = s1_tab[2]; src2 = s2_tab[2]; src3 = s3_tab[2]; dst = dcur[2];
    #1;
    chk("clear_inready", 32'(in_ready), 32'd0);
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) send(5'h1F, 1'b1, 4'hF, 1'b1, 5'h1F);
    wait_frame();
    check_frame("ones", 124, 0, 0, 0);
    handshake("ones");

    // asynchronous reset while a summary is held, then mid-frame
    dcur = '{5'h0F, 5'h0E, 5'h10, 5'h0F};
    send_frame(0);
    wait_frame();
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    dcur = '{5'h00, 5'h00, 5'h14, 5'h0F};
    send(s0_tab[0], s1_tab[0], s2_tab[0], s3_tab[0], dcur[0]);
    send(s0_tab[1], s1_tab[1], s2_tab[1], s3_tab[1], dcur[1]);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_inready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    dcur = '{5'h0F, 5'h0E, 5'h14, 5'h0F};
    send_frame(0);
    wait_frame();
    check_frame("post_rst", 64, 0, 0, 0);
    handshake("post_rst");

    // gapped input over two consecutive frames
    dcur = '{5'h0F, 5'h0E, 5'h10, 5'h0F};
    send_frame(1);
    wait_frame();
    check_frame("gap1", 60, 1, 1, 2);
    handshake("gap1");
    dcur = '{5'h0F, 5'h00, 5'h14, 5'h00};
    send_frame(1);
    wait_frame();
    check_frame("gap2", 35, 2, 1, 1);
    handshake("gap2");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gpc1415_frame_checker.md
Name: gpc1415_frame_checker

Overview:
- Streaming stage directly downstream of gpc1415_5.
- Accepts each GPC input vector (src0..src3) together with the GPC's 5-bit result dst over a valid/ready handshake, and recomputes the weighted column sum.
- Flags mismatches and accumulates results over frames of FRAME_LEN samples.
- Emits one registered frame summary per frame (sum, error count, first-error index) over a second valid/ready handshake. Used for on-chip self-check of GPC instances in compressor trees.

Parameters:
- FRAME_LEN, 16, samples per frame (>=2).
- CNT_W, $clog2(FRAME_LEN+1), width of sample index and error counters.
- ACC_W, $clog2(31*FRAME_LEN+1), width of frame sum accumulator.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous drop of partially accumulated frame.
- in_valid  input  1  sample valid.
- in_ready  output  1  sample accepted when in_valid&&in_ready.
- src0  input  5  column weight 1 bits.
- src1  input  1  column weight 2 bit.
- src2  input  4  column weight 4 bits.
- src3  input  1  column weight 8 bit.
- dst  input  5  gpc1415_5 result for the same src vector.
- frame_valid  output  1  frame summary valid.
- frame_ready  input  1  consumer accepts summary.
- frame_sum  output  ACC_W  sum of dst over frame.
- frame_err_cnt  output  CNT_W  number of samples with dst != reference.
- frame_err  output  1  frame_err_cnt != 0.
- frame_first_err_idx  output  CNT_W  index (0-based) of first mismatch; 0 if none.

Behaviour:
- Clock/reset: single clock clk; rst_n asynchronous, active-low.
- Reset values: all outputs 0 except in_ready=1. Stage register, accumulators and index are cleared; state=ACCUM.
- Reference sum: popcount(src0) + 2*src1 + 4*popcount(src2) + 8*src3, range 0..31, 5-bit unsigned. Compared against dst at full 5-bit width.
- Pipeline stage S1: on an accept edge, register src fields, dst and a last flag (idx==FRAME_LEN-1); s1_valid=1. Otherwise s1_valid=0.
- Pipeline stage S2 (edge after S1 capture):
  - acc += dst, zero-extended to ACC_W; no overflow possible by construction of ACC_W.
  - On mismatch: err_cnt += 1; if err_cnt was 0, record the sample index.
  - If last: copy the updated values into the frame_* output registers, set frame_valid=1, and zero the accumulators.
- FSM states and transitions:
  - ACCUM: in_ready=1. Accepting the last sample moves to DRAIN.
  - DRAIN: in_ready=0; lasts one cycle while S1 holds the last sample; moves to HOLD as frame_valid rises.
  - HOLD: in_ready=0; frame_* held stable. frame_valid&&frame_ready moves to ACCUM, with frame_valid cleared at that edge.
- Latency: frame_valid is high in the cycle after the second edge following acceptance of the last sample. in_ready returns high in the cycle after the frame handshake.
- Sample index: increments on accept and wraps to 0 after FRAME_LEN-1.
- clear:
  - In ACCUM or DRAIN: zero idx and accumulators, discard S1 contents (s1_valid=0), go to ACCUM. A sample presented in the same cycle is not accepted: in_ready is forced 0 while clear=1.
  - In HOLD: ignored; the summary is preserved.
- Backpressure: frame_ready may be high before frame_valid; no combinational path from frame_ready to in_ready.
- Mid-operation reset: rst_n low at any point immediately forces reset values; the partial frame is lost.

Decomposition:
- Package gpc1415_pkg:
  - column widths (5,1,4,1) and weights (1,2,4,8), MAX_SUM=31, SUM_W=5;
  - state enum (ACCUM, DRAIN, HOLD);
  - function weighted_sum.
- One combinational sub-module, gpc1415_refsum (src0..src3 -> 5-bit reference), instantiated in S2. It is reusable by sibling GPC checkers.

Test Plan:
- FRAME_LEN=4; four samples with correct dst: (08,1,E,0)->0F, (14,0,4,1)->0E, (0C,1,5,1)->14, (19,0,2,1)->0F -> frame_sum=64, frame_err_cnt=0, frame_err=0, frame_first_err_idx=0.
- Same four samples, but sample 2 driven with dst=10 -> frame_sum=60, frame_err_cnt=1, frame_err=1, frame_first_err_idx=2.
- frame_ready held low 5 cycles after frame_valid -> frame_* stable and in_ready=0 throughout; handshake, then in_ready=1 the next cycle and a new frame accepted.
- clear after 2 accepted samples (third sample presented with clear=1 is not accepted) -> next four samples, each all-ones src with dst=1F, give frame_sum=124, frame_err_cnt=0.
- rst_n pulsed low asynchronously mid-frame, between edges -> all outputs 0 and in_ready=1 immediately; subsequent frame matches the first scenario's values.
- in_valid toggled every other cycle over a frame -> same frame results as back-to-back input; idx wraps correctly across two consecutive frames.
